// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine: FSM states,
// decider window widths and the arctangent table (atan(2^-i) * 2^13, rounded).
package cordic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEC_XW = 4;
   localparam int DEC_YW = 4;
   localparam int DEC_ZW = 3;
   localparam int DEC_AW = 5;

   // Entry 14 is 0.49999..., so it rounds down; the tail is all zero.
   localparam int ATAN [32] = '{
      6434, 3798, 2007, 1019, 511, 256, 128, 64,
      32,   16,   8,    4,    2,   1,   0,   0,
      0,    0,    0,    0,    0,   0,   0,   0,
      0,    0,    0,    0,    0,   0,   0,   0
   };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational iteration-index to micro-rotation angle lookup, no latency.
// The angle is truncated to the datapath width; there is no flow control.
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [DEC_AW-1:0] idx,
   output logic [WIDTH-1:0]  angle
);

   always_comb begin
      angle = WIDTH'(ATAN[idx]);
   end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC rotation: one micro-rotation per cycle, result valid ITER+1 cycles after start.
// The result is held in DONE until out_ready; start is ignored unless IDLE.
module cordic_iter
   import cordic_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ITER  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     x_in,
   input  logic [WIDTH-1:0]     y_in,
   input  logic [WIDTH-1:0]     z_in,
   input  logic [2:0]           ex_in,
   input  logic [2:0]           ey_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     x_out,
   output logic [WIDTH-1:0]     y_out,
   output logic [WIDTH-1:0]     z_out,
   output logic                 busy,
   output logic                 err,
   output logic                 dec_v,
   output logic [DEC_XW-1:0]    dec_x,
   output logic [DEC_YW-1:0]    dec_y,
   output logic [DEC_ZW-1:0]    dec_z,
   output logic [DEC_AW-1:0]    dec_a,
   output logic [2:0]           dec_ex,
   output logic [2:0]           dec_ey,
   input  logic                 d,
   input  logic                 dn
);

   state_t                   state;
   logic [DEC_AW-1:0]        i;
   logic signed [WIDTH-1:0]  x, y, z;
   logic [2:0]               ex, ey;
   logic signed [WIDTH-1:0]  atan_i;
   logic signed [WIDTH-1:0]  x_sh, y_sh;
   logic signed [WIDTH-1:0]  x_nx, y_nx, z_nx;
   logic                     sig_pos, sig_neg, dig_bad;
   logic                     last_iter;

   cordic_atan_rom #(.WIDTH(WIDTH)) u_atan_rom (
      .idx   (i),
      .angle (atan_i)
   );

   assign sig_pos   = d & ~dn;
   assign sig_neg   = dn & ~d;
   assign dig_bad   = d & dn;
   assign last_iter = (i == DEC_AW'(ITER - 1));

   // Arithmetic shift past the width naturally saturates to 0 or -1.
   assign x_sh = x >>> i;
   assign y_sh = y >>> i;

   always_comb begin
      x_nx = x;
      y_nx = y;
      z_nx = z;
      if (sig_pos) begin
         x_nx = x - y_sh;
         y_nx = y + x_sh;
         z_nx = z - atan_i;
      end else if (sig_neg) begin
         x_nx = x + y_sh;
         y_nx = y - x_sh;
         z_nx = z + atan_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         i         <= '0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         ex        <= '0;
         ey        <= '0;
         x_out     <= '0;
         y_out     <= '0;
         z_out     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         dec_v     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x     <= x_in;
                  y     <= y_in;
                  z     <= z_in;
                  ex    <= ex_in;
                  ey    <= ey_in;
                  i     <= '0;
                  err   <= 1'b0;
                  busy  <= 1'b1;
                  dec_v <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               x <= x_nx;
               y <= y_nx;
               z <= z_nx;
               if (dig_bad) begin
                  err <= 1'b1;
               end
               if (last_iter) begin
                  x_out     <= x_nx;
                  y_out     <= y_nx;
                  z_out     <= z_nx;
                  out_valid <= 1'b1;
                  dec_v     <= 1'b1;
                  state     <= DONE;
               end else begin
                  i <= i + DEC_AW'(1);
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign dec_x  = x[WIDTH-1 -: DEC_XW];
   assign dec_y  = y[WIDTH-1 -: DEC_YW];
   assign dec_z  = z[WIDTH-1 -: DEC_ZW];
   assign dec_a  = i;
   assign dec_ex = ex;
   assign dec_ey = ey;

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter; results are checked by a scoreboard monitor on each handshake.
module tb_cordic_iter;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      logic        err;
   } exp_t;

   logic        clk, rst, start, out_ready, d, dn;
   logic [15:0] x_in, y_in, z_in;
   logic [2:0]  ex_in, ey_in;
   logic        out_valid, busy, err, dec_v;
   logic [15:0] x_out, y_out, z_out;
   logic [3:0]  dec_x, dec_y;
   logic [2:0]  dec_z, dec_ex, dec_ey;
   logic [4:0]  dec_a;

   int   checks = 0;
   int   failures = 0;
   int   mode = 0;   // 0: no digits, 1: d always, 2: d always with d&dn at i=3
   exp_t sb[$];

   cordic_iter #(.WIDTH(16), .ITER(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .ex_in(ex_in), .ey_in(ey_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .x_out(x_out), .y_out(y_out), .z_out(z_out),
      .busy(busy), .err(err), .dec_v(dec_v),
      .dec_x(dec_x), .dec_y(dec_y), .dec_z(dec_z), .dec_a(dec_a),
      .dec_ex(dec_ex), .dec_ey(dec_ey),
      .d(d), .dn(dn)
   );

   // Combinational decider stand-in
   assign d  = (mode == 1) || (mode == 2);
   assign dn = (mode == 2) && (dec_a == 5'd3);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // x/y after 16 micro-rotations, sigma=+1 where mask bit set, else 0
   function automatic logic [31:0] rot_xy(input logic [15:0] x0, input logic [15:0] y0,
                                          input logic [31:0] mask);
      logic signed [15:0] xv, yv, xt;
      xv = x0;
      yv = y0;
      for (int k = 0; k < 16; k++) begin
         if (mask[k]) begin
            xt = xv - (yv >>> k);
            yv = yv + (xv >>> k);
            xv = xt;
         end
      end
      return {xv, yv};
   endfunction

   task automatic issue(input logic [15:0] xa, input logic [15:0] ya, input logic [15:0] za,
                        input logic [2:0] ea, input logic [2:0] eb);
      x_in  = xa;
      y_in  = ya;
      z_in  = za;
      ex_in = ea;
      ey_in = eb;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int bound);
      int n;
      n = 0;
      while (!out_valid && n < bound) begin
         step();
         n++;
      end
      chk(name, out_valid, 1);
   endtask

   task automatic push(input logic [15:0] xe, input logic [15:0] ye, input logic [15:0] ze,
                       input logic ee);
      exp_t e;
      e.x = xe;
      e.y = ye;
      e.z = ze;
      e.err = ee;
      sb.push_back(e);
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: got result 0x%0h expected none", x_out);
            end else begin
               e = sb.pop_front();
               chk("sb_x", x_out, e.x);
               chk("sb_y", y_out, e.y);
               chk("sb_z", z_out, e.z);
               chk("sb_err", err, e.err);
            end
         end
      end
   end

   initial begin
      logic [31:0] xy;
      int cyc;
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      x_in = '0; y_in = '0; z_in = '0; ex_in = '0; ey_in = '0;
      repeat (2) step();
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_dec_v", dec_v, 1);
      chk("rst_windows", {dec_x, dec_y, dec_z, dec_a, dec_ex, dec_ey}, 0);
      chk("rst_xout", x_out, 0);
      rst = 1'b0;
      step();

      // Zero digits: identity, latency, decider interface
      mode = 0;
      chk("idle_dec_v", dec_v, 1);
      push(16'h1234, 16'hF00D, 16'h0100, 1'b0);
      issue(16'h1234, 16'hF00D, 16'h0100, 3'b101, 3'b010);
      cyc = 1;
      for (int k = 0; k < 16; k++) begin
         chk("run_dec_a", dec_a, k);
         chk("run_dec_v", dec_v, 0);
         chk("run_exey", {dec_ex, dec_ey}, {3'b101, 3'b010});
         chk("run_not_valid", out_valid, 0);
         step();
         cyc++;
      end
      chk("latency_cycles", cyc, 17);
      chk("latency_valid", out_valid, 1);
      chk("done_dec_v", dec_v, 1);
      chk("done_busy", busy, 1);
      step();
      chk("hs_idle_busy", busy, 0);

      // Single-digit steps with d held
      mode = 1;
      xy = rot_xy(16'h2000, 16'h0000, 32'hFFFF_FFFF);
      push(xy[31:16], xy[15:0], 16'hC838, 1'b0);
      issue(16'h2000, 16'h0000, 16'h0000, 3'b000, 3'b000);
      step();
      chk("edge1_dec_x", dec_x, 4'h2);
      chk("edge1_dec_y", dec_y, 4'h2);
      chk("edge1_dec_z", dec_z, 3'b111);
      chk("edge1_dec_a", dec_a, 1);
      wait_valid("d1_valid_timeout", 40);
      step();

      // Illegal digit at i=3 only
      mode = 2;
      xy = rot_xy(16'h2000, 16'h0000, 32'hFFFF_FFF7);
      push(xy[31:16], xy[15:0], 16'hCC33, 1'b1);
      issue(16'h2000, 16'h0000, 16'h0000, 3'b000, 3'b000);
      repeat (3) step();
      chk("err_before_edge4", err, 0);
      step();
      chk("err_after_edge4", err, 1);
      wait_valid("ill_valid_timeout", 40);
      chk("err_held_done", err, 1);
      step();
      chk("err_held_idle", err, 1);

      // Backpressure with ignored start pulses
      mode = 0;
      out_ready = 1'b0;
      push(16'h0AAA, 16'h0555, 16'h7FFF, 1'b0);
      issue(16'h0AAA, 16'h0555, 16'h7FFF, 3'b000, 3'b000);
      chk("err_cleared_start", err, 0);
      wait_valid("bp_valid_timeout", 40);
      x_in = 16'hFFFF; y_in = 16'hFFFF; z_in = 16'hFFFF;
      start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_valid", out_valid, 1);
         chk("bp_busy", busy, 1);
         chk("bp_xout", x_out, 16'h0AAA);
         chk("bp_zout", z_out, 16'h7FFF);
      end
      out_ready = 1'b1;
      step();
      chk("bp_hs_busy", busy, 0);
      chk("bp_hs_valid", out_valid, 0);
      start = 1'b0;
      step();
      chk("bp_start_not_queued", busy, 0);

      // Reset mid-RUN discards the in-flight result
      mode = 1;
      issue(16'h1000, 16'h0100, 16'h0010, 3'b000, 3'b000);
      repeat (5) step();
      chk("mid_dec_a", dec_a, 5);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_dec_v", dec_v, 1);
      chk("mid_rst_xout", x_out, 0);
      step();
      rst = 1'b0;
      step();
      mode = 0;
      push(16'h0123, 16'h0456, 16'h0789, 1'b0);
      issue(16'h0123, 16'h0456, 16'h0789, 3'b011, 3'b100);
      wait_valid("post_rst_valid_timeout", 40);
      repeat (2) step();
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
